// File: rtl/ascon_pack.sv
// Shared types and default round counts for the Ascon round controller.
package ascon_pack;

    localparam int unsigned NB_ROUNDS_A_DEF = 12;
    localparam int unsigned NB_ROUNDS_B_DEF = 6;

    typedef logic [3:0] round_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/ascon_round_counter.sv
// Round-index counter: synchronous clear, load and saturating increment.
module ascon_round_counter
    import ascon_pack::*;
#(
    parameter round_idx_t MAX_VAL = 4'd11
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  round_idx_t load_val_i,
    input  logic       inc_i,
    output round_idx_t count_o
);

    round_idx_t count_d;
    round_idx_t count_q;

    // Clear beats load beats increment; the count parks at MAX_VAL rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 4'd0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ascon_round_ctrl.sv
// Ascon permutation round controller (IDLE/RUN/DONE) driving the state mux and round index.
// Optional feature: define ASCON_ABORT_EN to add the abort_i port.
module ascon_round_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned NB_ROUNDS_A = NB_ROUNDS_A_DEF,
    parameter int unsigned NB_ROUNDS_B = NB_ROUNDS_B_DEF
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_i,
`ifdef ASCON_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       ready_o,
    output logic       sel_state_o,
    output logic       en_state_o,
    output round_idx_t round_o,
    output logic       done_o
);

    localparam round_idx_t LAST_IDX    = round_idx_t'(NB_ROUNDS_A - 1);
    localparam round_idx_t B_START_IDX = round_idx_t'(NB_ROUNDS_A - NB_ROUNDS_B);

    if ((NB_ROUNDS_B < 1) || (NB_ROUNDS_B > NB_ROUNDS_A) || (NB_ROUNDS_A > 16)) begin : g_param_chk
        $error("ascon_round_ctrl: need 1 <= NB_ROUNDS_B <= NB_ROUNDS_A <= 16");
    end

    ctrl_state_e state_d;
    ctrl_state_e state_q;
    logic        first_d;
    logic        first_q;
    logic        abort_s;
    logic        cnt_clear_s;
    logic        cnt_load_s;
    logic        cnt_inc_s;
    round_idx_t  cnt_load_val_s;
    round_idx_t  cnt_s;

`ifdef ASCON_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    ascon_round_counter #(
        .MAX_VAL (LAST_IDX)
    ) u_counter (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clear_i    (cnt_clear_s),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .inc_i      (cnt_inc_s),
        .count_o    (cnt_s)
    );

    // Next-state and counter control; p^b starts part-way so both modes end on LAST_IDX.
    always_comb begin
        state_d        = state_q;
        first_d        = 1'b0;
        cnt_clear_s    = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_inc_s      = 1'b0;
        cnt_load_val_s = mode_i ? B_START_IDX : 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    cnt_load_s = 1'b1;
                    first_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_d     = ST_IDLE;
                    cnt_clear_s = 1'b1;
                end else if (cnt_s == LAST_IDX) begin
                    state_d     = ST_DONE;
                    cnt_clear_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cnt_clear_s = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_clear_s = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Moore decode from state, first-round flag and counter.
    always_comb begin
        ready_o     = 1'b0;
        sel_state_o = 1'b0;
        en_state_o  = 1'b0;
        round_o     = 4'd0;
        done_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
            end
            ST_RUN: begin
                en_state_o  = 1'b1;
                sel_state_o = ~first_q;
                round_o     = cnt_s;
            end
            ST_DONE: begin
                done_o      = 1'b1;
                sel_state_o = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/ascon_round_ctrl.md
ASCON_ROUND_CTRL -- requirements
Module: ascon_round_ctrl

Interface
REQ-001 Parameter NB_ROUNDS_A, default 12: round count of permutation p^a.
REQ-002 Parameter NB_ROUNDS_B, default 6: round count of permutation p^b; SHALL satisfy 1 <= NB_ROUNDS_B <= NB_ROUNDS_A <= 16.
REQ-003 Port clock_i, input, 1: the single clock; all logic rising-edge.
REQ-004 Port reset_i, input, 1: synchronous, active-high reset.
REQ-005 Port start_i, input, 1: permutation request, accepted only when ready_o=1.
REQ-006 Port mode_i, input, 1: sampled on acceptance; 0 = p^a, 1 = p^b.
REQ-007 Port ready_o, output, 1: controller idle, can accept start_i.
REQ-008 Port sel_state_o, output, 1: state-mux select; 0 = external data, 1 = feedback of the state register.
REQ-009 Port en_state_o, output, 1: state-register load enable.
REQ-010 Port round_o, output, 4: round-constant index for the current round.
REQ-011 Port done_o, output, 1: one-cycle pulse after the last round.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be Moore outputs decoded from the state and the round counter.
REQ-013 IDLE: ready_o=1, en_state_o=0, sel_state_o=0, done_o=0, round_o=0.
REQ-014 IDLE with start_i=1: SHALL go to RUN and load the counter with 0 (mode 0) or NB_ROUNDS_A-NB_ROUNDS_B (mode 1).
REQ-015 RUN: en_state_o=1, ready_o=0, round_o=counter; sel_state_o=0 in the first RUN cycle only, else 1.
REQ-016 RUN: the counter SHALL increment each cycle; when counter = NB_ROUNDS_A-1, the next state SHALL be DONE.
REQ-017 DONE: done_o=1, en_state_o=0, ready_o=0, sel_state_o=1, round_o=0; the next state SHALL be IDLE unconditionally.
REQ-018 Latency: start accepted at edge t; RUN occupies cycles t+1..t+N (N=12 or 6); done_o is high in cycle t+N+1; ready_o returns in cycle t+N+2.
REQ-019 start_i and mode_i SHALL be ignored outside IDLE; mode_i changes during RUN SHALL NOT affect the sequence.
REQ-020 The counter SHALL never exceed NB_ROUNDS_A-1 and SHALL never wrap.

Reset
REQ-021 When reset_i=1 at a clock edge, the state SHALL be IDLE and the counter 0, overriding start_i and any in-flight RUN/DONE; no done_o SHALL follow.
REQ-022 After reset, outputs SHALL be ready_o=1, en_state_o=0, sel_state_o=0, done_o=0, round_o=0.

Configuration
REQ-023 Macro ASCON_ABORT_EN, when defined, SHALL add port abort_i (input, 1); abort_i=1 in RUN or DONE SHALL force IDLE at the next edge with no done_o pulse.
REQ-024 If abort_i coincides with the last RUN cycle, abort SHALL win and done_o SHALL stay 0; abort_i in IDLE SHALL be ignored and SHALL NOT block a simultaneous start_i.
REQ-025 Without ASCON_ABORT_EN, the port SHALL be absent and behaviour SHALL be REQ-012..022 unchanged.

Structure
REQ-026 Package ascon_pack SHALL hold the FSM enum type, the 4-bit round-index typedef, and constants for default NB_ROUNDS_A and NB_ROUNDS_B.
REQ-027 The counter SHALL be a sub-module named ascon_round_counter with synchronous load, increment and clear; the FSM SHALL stay in ascon_round_ctrl.

Verification
REQ-028 Reset, then start_i=1 with mode_i=0 for one cycle -> 12 RUN cycles with round_o 0..11 and sel_state_o 0,1,...,1; done_o at cycle 13; ready_o at cycle 14.
REQ-029 start_i=1 with mode_i=1 -> round_o 6..11 over 6 cycles; done_o at cycle 7.
REQ-030 start_i held at 1 and mode_i toggled during RUN -> no restart and no change of round_o sequence; a new start is accepted in the first IDLE cycle after DONE.
REQ-031 reset_i=1 when round_o=5 -> next cycle IDLE, all outputs at reset values, no done_o.
REQ-032 With ASCON_ABORT_EN: abort_i=1 when round_o=11 -> IDLE next cycle, done_o never asserted; abort_i with start_i in IDLE -> start accepted.
REQ-033 Back-to-back mode 1 requests -> done_o pulses spaced 8 cycles apart, en_state_o low in every DONE and IDLE cycle.
